bypass_pipeline: RTL and testbench
==================================

Name: bypass_pipeline

Overview:
Parametrised writeback pipeline with an integrated forwarding network. It generalises the fixed E/M/W result-register chain and its bypass muxes. Results enter at stage 0 and advance through STAGES registers with per-stage stall/flush, then retire at the last stage as the register-file write. NREAD read ports search all in-flight results for the youngest matching destination. They return forwarded data, or flag a hazard when that result is a late (memory/coprocessor) result not yet produced.

Parameters:
WIDTH, 32, data word width
TAGW, 4, destination register tag width
STAGES, 3, pipeline depth (>=2); stage STAGES-1 is writeback
NREAD, 2, number of forwarding read ports
LATE_STAGE, 1, stage whose late_data completes late results (0 <= LATE_STAGE < STAGES-1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  new result enters stage 0
in_tag  in  TAGW  destination register of new result
in_data  in  WIDTH  result data (ignored if in_late)
in_late  in  1  data supplied later via late_data
late_data  in  WIDTH  completion data for the late entry in LATE_STAGE
stall  in  STAGES  per-stage hold
flush  in  STAGES  per-stage invalidate
rd_tag  in  NREAD*TAGW  per-port lookup tag
rd_rfdata  in  NREAD*WIDTH  per-port register-file data (fallback)
rd_data  out  NREAD*WIDTH  per-port operand after bypass
rd_hazard  out  NREAD  per-port: youngest match not ready
out_valid  out  1  stage STAGES-1 valid (regfile write enable)
out_tag  out  TAGW  writeback tag
out_data  out  WIDTH  writeback data
busy  out  1  any stage valid

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high. On reset, every stage clears valid, ready, late, tag and data to 0. out_valid, out_tag, out_data and busy read 0 the cycle after reset. Reset overrides every other input, including mid-flight entries.
- Stage entry fields: valid, tag, data, ready. ready = 1 at insertion iff !in_late.
- Update priority for stage k at each edge: reset > flush[k] > stall[k] > advance.
  - flush[k]: valid <= 0. Flush is not gated by stall.
  - stall[k]: entry holds all fields.
  - advance, k=0: loads {in_valid, in_tag, in_data, !in_late}.
  - advance, k>0 with stall[k-1]=0: loads stage k-1.
  - advance, k>0 with stall[k-1]=1: loads a bubble (valid=0).
- Late completion: when a valid, !ready entry advances from LATE_STAGE to LATE_STAGE+1, the new stage captures data=late_data and ready=1. Entries that pass through ready keep their data. A late entry never reaches stage LATE_STAGE+1 unready.
- Outputs:
  - out_* are stage STAGES-1 fields, driven directly from registers (no combinational path from inputs).
  - busy is the OR of all valid bits, combinational from registers.
  - Latency: an insertion at edge n appears on out_* after edge n+STAGES-1 when no stalls occur, i.e. STAGES edges from sampling.
- Forwarding, per port p, combinational from stage registers only:
  - Search stages 0..STAGES-1 in order and select the lowest-index stage with valid && tag==rd_tag[p]. Younger results win.
  - Selected entry ready: rd_data = entry data, rd_hazard = 0.
  - Selected entry not ready: rd_hazard = 1 and rd_data = rd_rfdata[p]. An older ready match is NOT used.
  - No match: rd_data = rd_rfdata[p], rd_hazard = 0.
- Bubbles and flushed entries never match.
- Same-cycle insertion is not visible to lookups until the next cycle.
- No internal stall generation: the consumer drives stall/flush from rd_hazard.

Test Plan:
- Idle, default parameters. Assert reset 2 cycles, release; rd_tag={2,1}, rd_rfdata={0xAAAA0000,0x5555}. Required: rd_data={0xAAAA0000,0x5555}, rd_hazard=0, out_valid=0, busy=0.
- Basic forward and latency. in_valid=1, tag=3, data=0xDEADBEEF for one cycle. Next cycle rd_tag[0]=3 gives rd_data[0]=0xDEADBEEF, hazard 0. out_valid=1 with out_tag=3, out_data=0xDEADBEEF exactly 3 edges after insertion, for exactly one cycle.
- Youngest wins. Insert tag 5 with 0x11, then tag 5 with 0x22 on consecutive cycles. Next cycle rd_tag=5 gives 0x22. After the 0x22 entry is flushed in stage 0 via flush[0], the lookup gives 0x11.
- Late result. Insert tag 7 with in_late=1. While it sits in stages 0 and 1, rd_tag=7 gives hazard=1 and rd_data=rd_rfdata. Drive late_data=0xCAFE0000 while it is in stage 1. Next cycle hazard=0 and rd_data=0xCAFE0000; out_data=0xCAFE0000 at writeback.
- Stall and bubble. With valid entries A in stage 0 and B in stage 1, set stall={0,0,1}→stall[0]=1 for one cycle. Required: A held in stage 0, stage 1 becomes a bubble, B in stage 2. Then stall[1]=1 together with flush[1]=1: stage 1 valid=0 next cycle.
- Reset mid-flight. Fill all 3 stages with valid entries, assert reset one cycle. Next cycle out_valid=0, busy=0, out_data=0, and every lookup returns rd_rfdata.

Source files
------------

// File: rtl/bypass_pipeline_if.sv
// Port bundle for bypass_pipeline: result insertion, per-stage control,
// forwarding lookups and the writeback port.
interface bypass_pipeline_if #(
  parameter int WIDTH  = 32,
  parameter int TAGW   = 4,
  parameter int STAGES = 3,
  parameter int NREAD  = 2
);
  logic                   in_valid;
  logic [TAGW-1:0]        in_tag;
  logic [WIDTH-1:0]       in_data;
  logic                   in_late;
  logic [WIDTH-1:0]       late_data;
  logic [STAGES-1:0]      stall;
  logic [STAGES-1:0]      flush;
  logic [NREAD*TAGW-1:0]  rd_tag;
  logic [NREAD*WIDTH-1:0] rd_rfdata;
  logic [NREAD*WIDTH-1:0] rd_data;
  logic [NREAD-1:0]       rd_hazard;
  logic                   out_valid;
  logic [TAGW-1:0]        out_tag;
  logic [WIDTH-1:0]       out_data;
  logic                   busy;

  modport master (
    output in_valid, in_tag, in_data, in_late, late_data, stall, flush,
           rd_tag, rd_rfdata,
    input  rd_data, rd_hazard, out_valid, out_tag, out_data, busy
  );

  modport slave (
    input  in_valid, in_tag, in_data, in_late, late_data, stall, flush,
           rd_tag, rd_rfdata,
    output rd_data, rd_hazard, out_valid, out_tag, out_data, busy
  );
endinterface

// File: rtl/bypass_pipeline.sv
// Writeback result pipeline with per-stage stall/flush, late-result completion
// and a youngest-match forwarding network feeding NREAD operand read ports.
module bypass_pipeline #(
  parameter int WIDTH      = 32,
  parameter int TAGW       = 4,
  parameter int STAGES     = 3,
  parameter int NREAD      = 2,
  parameter int LATE_STAGE = 1
) (
  input  logic             clk,
  input  logic             reset,
  bypass_pipeline_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic             ready;
    logic [TAGW-1:0]  tag;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t stage_q [STAGES];
  entry_t stage_d [STAGES];

  logic [NREAD*WIDTH-1:0] fwd_data;
  logic [NREAD-1:0]       fwd_hazard;
  logic                   found;
  logic                   any_valid;

  // Per-stage update: flush beats stall, stall beats advance.
  always_comb begin
    // NOTE: every stage_d entry gets a default first so no path leaves it unassigned (no latch).
    for (int k = 0; k < STAGES; k++) stage_d[k] = stage_q[k];

    if (bus.flush[0]) begin
      stage_d[0].valid = 1'b0;
    end else if (!bus.stall[0]) begin
      stage_d[0].valid = bus.in_valid;
      stage_d[0].ready = !bus.in_late;
      stage_d[0].tag   = bus.in_tag;
      stage_d[0].data  = bus.in_data;
    end

    for (int k = 1; k < STAGES; k++) begin
      if (bus.flush[k]) begin
        stage_d[k].valid = 1'b0;
      end else if (!bus.stall[k]) begin
        if (bus.stall[k-1]) begin
          stage_d[k].valid = 1'b0;
        end else begin
          stage_d[k] = stage_q[k-1];
          // A late result picks up its data as it leaves the completing stage.
          if ((k - 1) == LATE_STAGE && stage_q[k-1].valid && !stage_q[k-1].ready) begin
            stage_d[k].data  = bus.late_data;
            stage_d[k].ready = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the stage array is small and its clear is architecturally visible, so it is reset like any register.
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
      for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int k = 0; k < STAGES; k++) any_valid = any_valid | stage_q[k].valid;
  end

  // Lowest-index match is the youngest; an unready youngest match blocks older ones.
  always_comb begin
    fwd_data   = bus.rd_rfdata;
    fwd_hazard = '0;
    found      = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      found = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        if (!found && stage_q[k].valid && stage_q[k].tag == bus.rd_tag[p*TAGW +: TAGW]) begin
          found = 1'b1;
          if (stage_q[k].ready) fwd_data[p*WIDTH +: WIDTH] = stage_q[k].data;
          else                  fwd_hazard[p]              = 1'b1;
        end
      end
    end
  end

  assign bus.rd_data   = fwd_data;
  assign bus.rd_hazard = fwd_hazard;
  assign bus.out_valid = stage_q[STAGES-1].valid;
  assign bus.out_tag   = stage_q[STAGES-1].tag;
  assign bus.out_data  = stage_q[STAGES-1].data;
  assign bus.busy      = any_valid;

endmodule

// File: tb/tb_bypass_pipeline.sv
// Self-checking bench for bypass_pipeline: writeback scoreboard plus inline
// forwarding/hazard checks, one task per scenario.
module tb_bypass_pipeline;
  localparam int WIDTH  = 32;
  localparam int TAGW   = 4;
  localparam int STAGES = 3;
  localparam int NREAD  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bypass_pipeline_if #(.WIDTH(WIDTH), .TAGW(TAGW), .STAGES(STAGES), .NREAD(NREAD)) bus ();

  bypass_pipeline #(
    .WIDTH(WIDTH), .TAGW(TAGW), .STAGES(STAGES), .NREAD(NREAD), .LATE_STAGE(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [TAGW-1:0]  tag;
    logic [WIDTH-1:0] data;
  } wb_t;

  wb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  // Writeback monitor: each out_valid cycle must match the oldest expected result.
  always @(negedge clk) begin : wb_mon
    wb_t e;
    if (bus.out_valid === 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got tag %0d data %h, want no writeback", bus.out_tag, bus.out_data);
      end else begin
        e = sb_q.pop_front();
        if (bus.out_tag !== e.tag || bus.out_data !== e.data) begin
          n_err++;
          $display("FAIL wb_entry: got tag %0d data %h, want tag %0d data %h",
                   bus.out_tag, bus.out_data, e.tag, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_tag    = '0;
    bus.in_data   = '0;
    bus.in_late   = 1'b0;
    bus.late_data = '0;
    bus.stall     = '0;
    bus.flush     = '0;
  endtask

  task automatic drive_result(input logic [TAGW-1:0] tag, input logic [WIDTH-1:0] data,
                              input logic late, input logic [WIDTH-1:0] exp_data);
    bus.in_valid = 1'b1;
    bus.in_tag   = tag;
    bus.in_data  = data;
    bus.in_late  = late;
    sb_q.push_back('{tag: tag, data: exp_data});
  endtask

  task automatic set_port(input int p, input logic [TAGW-1:0] tag, input logic [WIDTH-1:0] rf);
    bus.rd_tag[p*TAGW +: TAGW]      = tag;
    bus.rd_rfdata[p*WIDTH +: WIDTH] = rf;
  endtask

  function automatic logic [WIDTH-1:0] port_data(input int p);
    return bus.rd_data[p*WIDTH +: WIDTH];
  endfunction

  task automatic test_reset();
    idle();
    bus.rd_tag    = '0;
    bus.rd_rfdata = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    set_port(1, 4'd2, 32'hAAAA0000);
    set_port(0, 4'd1, 32'h00005555);
    #1;
    n_vec++; if (bus.rd_data !== {32'hAAAA0000, 32'h00005555}) begin n_err++; $display("FAIL reset_rd_data: got %h want %h", bus.rd_data, {32'hAAAA0000, 32'h00005555}); end
    n_vec++; if (bus.rd_hazard !== 2'b00) begin n_err++; $display("FAIL reset_hazard: got %b want 00", bus.rd_hazard); end
    n_vec++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_valid_busy: got %b/%b want 0/0", bus.out_valid, bus.busy); end
    n_vec++; if (bus.out_tag !== 4'd0 || bus.out_data !== 32'd0) begin n_err++; $display("FAIL reset_out_fields: got %0d/%h want 0/0", bus.out_tag, bus.out_data); end
  endtask

  task automatic test_basic_forward();
    step();
    drive_result(4'd3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
    step();
    idle();
    set_port(0, 4'd3, 32'h0BAD0BAD);
    set_port(1, 4'd6, 32'h66666666);
    #1;
    n_vec++; if (port_data(0) !== 32'hDEADBEEF || bus.rd_hazard[0] !== 1'b0) begin n_err++; $display("FAIL basic_fwd: got %h hz %b want deadbeef hz 0", port_data(0), bus.rd_hazard[0]); end
    n_vec++; if (port_data(1) !== 32'h66666666) begin n_err++; $display("FAIL basic_nomatch: got %h want 66666666", port_data(1)); end
    n_vec++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_busy: got busy %b ov %b want 1/0", bus.busy, bus.out_valid); end
    for (int e = 2; e <= 4; e++) begin
      step();
      n_vec++; if (bus.out_valid !== (e == 3)) begin n_err++; $display("FAIL basic_latency edge %0d: got out_valid %b want %b", e, bus.out_valid, (e == 3)); end
    end
  endtask

  task automatic test_youngest_wins();
    drive_result(4'd5, 32'h00000011, 1'b0, 32'h00000011);
    step();
    drive_result(4'd5, 32'h00000022, 1'b0, 32'h00000022);
    step();
    idle();
    set_port(0, 4'd5, 32'hF0F0F0F0);
    #1;
    n_vec++; if (port_data(0) !== 32'h00000022) begin n_err++; $display("FAIL young_pick: got %h want 00000022", port_data(0)); end
    // Kill the younger entry in stage 0 while keeping it out of stage 1.
    bus.stall = 3'b001;
    bus.flush = 3'b001;
    void'(sb_q.pop_back());
    step();
    idle();
    #1;
    n_vec++; if (port_data(0) !== 32'h00000011) begin n_err++; $display("FAIL young_after_flush: got %h want 00000011", port_data(0)); end
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00000011) begin n_err++; $display("FAIL young_wb: got %b/%h want 1/00000011", bus.out_valid, bus.out_data); end
    step();
    n_vec++; if (port_data(0) !== 32'hF0F0F0F0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL young_drained: got %h busy %b want f0f0f0f0 busy 0", port_data(0), bus.busy); end
  endtask

  task automatic test_late_result();
    drive_result(4'd7, 32'h00000077, 1'b0, 32'h00000077);
    step();
    drive_result(4'd7, 32'h00000BAD, 1'b1, 32'hCAFE0000);
    step();
    idle();
    set_port(0, 4'd7, 32'h00001234);
    #1;
    n_vec++; if (bus.rd_hazard[0] !== 1'b1 || port_data(0) !== 32'h00001234) begin n_err++; $display("FAIL late_stage0: got hz %b data %h want 1/00001234", bus.rd_hazard[0], port_data(0)); end
    step();
    bus.late_data = 32'hCAFE0000;
    #1;
    n_vec++; if (bus.rd_hazard[0] !== 1'b1 || port_data(0) !== 32'h00001234) begin n_err++; $display("FAIL late_stage1: got hz %b data %h want 1/00001234", bus.rd_hazard[0], port_data(0)); end
    step();
    bus.late_data = '0;
    #1;
    n_vec++; if (bus.rd_hazard[0] !== 1'b0 || port_data(0) !== 32'hCAFE0000) begin n_err++; $display("FAIL late_done: got hz %b data %h want 0/cafe0000", bus.rd_hazard[0], port_data(0)); end
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hCAFE0000) begin n_err++; $display("FAIL late_wb: got %b/%h want 1/cafe0000", bus.out_valid, bus.out_data); end
    step();
  endtask

  task automatic test_stall_bubble();
    drive_result(4'd2, 32'h0000B0B0, 1'b0, 32'h0000B0B0);
    step();
    drive_result(4'd1, 32'h0000A0A0, 1'b0, 32'h0000A0A0);
    step();
    idle();
    bus.stall = 3'b001;
    step();
    idle();
    set_port(0, 4'd1, 32'h11110000);
    set_port(1, 4'd2, 32'h22220000);
    #1;
    n_vec++; if (port_data(0) !== 32'h0000A0A0) begin n_err++; $display("FAIL stall_hold_a: got %h want 0000a0a0", port_data(0)); end
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd2 || port_data(1) !== 32'h0000B0B0) begin n_err++; $display("FAIL stall_b_wb: got %b/%0d/%h want 1/2/0000b0b0", bus.out_valid, bus.out_tag, port_data(1)); end
    step();
    n_vec++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL stall_bubble: got ov %b busy %b want 0/1", bus.out_valid, bus.busy); end
    bus.stall = 3'b010;
    bus.flush = 3'b010;
    void'(sb_q.pop_back());
    step();
    idle();
    #1;
    n_vec++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stall_flush: got busy %b ov %b want 0/0", bus.busy, bus.out_valid); end
    n_vec++; if (port_data(0) !== 32'h11110000 || bus.rd_hazard !== 2'b00) begin n_err++; $display("FAIL stall_flush_lookup: got %h hz %b want 11110000 hz 00", port_data(0), bus.rd_hazard); end
  endtask

  task automatic test_reset_midflight();
    drive_result(4'd8, 32'h11111111, 1'b0, 32'h11111111);
    step();
    drive_result(4'd9, 32'h22222222, 1'b0, 32'h22222222);
    step();
    drive_result(4'd8, 32'h33333333, 1'b1, 32'h33333333);
    step();
    idle();
    #1;
    n_vec++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL full_before_reset: got busy %b ov %b want 1/1", bus.busy, bus.out_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb_q.delete();
    set_port(0, 4'd8, 32'h000000AB);
    set_port(1, 4'd9, 32'h000000CD);
    #1;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 32'd0) begin n_err++; $display("FAIL midreset_out: got %b/%b/%h want 0/0/0", bus.out_valid, bus.busy, bus.out_data); end
    n_vec++; if (bus.rd_data !== {32'h000000CD, 32'h000000AB} || bus.rd_hazard !== 2'b00) begin n_err++; $display("FAIL midreset_lookup: got %h hz %b want 000000cd000000ab hz 00", bus.rd_data, bus.rd_hazard); end
  endtask

  initial begin
    test_reset();
    test_basic_forward();
    test_youngest_wins();
    test_late_result();
    test_stall_bubble();
    test_reset_midflight();
    repeat (4) step();
    n_vec++; if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d pending writebacks want 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
